// File: rtl/timer_unit.sv
// timer_unit: DIV/TIMA/TMA/TAC timer responder on the shared CPU data bus, with sticky timer irq.
// Build option: define TIMER_OVF_DELAY_EN for the 4-clock overflow reload delay (TIMA reads 00 meanwhile).
module timer_unit #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   inout  wire  [7:0]  databus,
   input  logic        RE,
   input  logic        WE,
   output logic        irq_timer,
   input  logic        irq_ack
);
   logic [15:0] sys_cnt, offs;
   logic [7:0]  tima, tma, rdata, wdata, tma_next;
   logic [2:0]  tac;
   logic        hit, wr_div, wr_tima, wr_tma, wr_tac;
   logic        sel, tick_in, tick_prev, inc;

   // Offset compare keeps the decode correct for any BASE_ADDR alignment.
   assign offs    = address - BASE_ADDR;
   assign hit     = (offs < 16'd4);
   assign wdata   = databus;
   assign wr_div  = WE && hit && (offs[1:0] == 2'd0);
   assign wr_tima = WE && hit && (offs[1:0] == 2'd1);
   assign wr_tma  = WE && hit && (offs[1:0] == 2'd2);
   assign wr_tac  = WE && hit && (offs[1:0] == 2'd3);

   always_comb begin
      rdata = 8'h00;
      case (offs[1:0])
         2'd0: rdata = sys_cnt[15:8];
         2'd1: rdata = tima;
         2'd2: rdata = tma;
         2'd3: rdata = {5'b11111, tac};
         default: rdata = 8'h00;
      endcase
   end

   assign databus = (RE && hit) ? rdata : 8'bz;

   always_comb begin
      sel = 1'b0;
      case (tac[1:0])
         2'd0: sel = sys_cnt[9];
         2'd1: sel = sys_cnt[3];
         2'd2: sel = sys_cnt[5];
         2'd3: sel = sys_cnt[7];
         default: sel = 1'b0;
      endcase
   end

   // Falling edge of the gated tap; DIV/TAC writes that drop it also count, as on the real part.
   assign tick_in  = sel & tac[2];
   assign inc      = tick_prev & ~tick_in;
   assign tma_next = wr_tma ? wdata : tma;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sys_cnt   <= 16'd0;
         tick_prev <= 1'b0;
         tac       <= 3'd0;
         tma       <= 8'd0;
      end else begin
         sys_cnt   <= wr_div ? 16'd0 : sys_cnt + 16'd1;
         tick_prev <= tick_in;
         if (wr_tac) tac <= wdata[2:0];
         if (wr_tma) tma <= wdata;
      end
   end

`ifdef TIMER_OVF_DELAY_EN
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_RELOAD = 2'd2;

   logic [1:0] state, cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tima      <= 8'd0;
         state     <= S_IDLE;
         cnt       <= 2'd0;
         irq_timer <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wr_tima) tima <= wdata;
               else if (inc) begin
                  if (tima == 8'hFF) begin
                     tima  <= 8'h00;
                     state <= S_WAIT;
                     cnt   <= 2'd3;
                  end else tima <= tima + 8'd1;
               end
            end
            S_WAIT: begin
               // A CPU write here cancels the pending reload and irq.
               if (wr_tima) begin
                  tima  <= wdata;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 2'd1;
                  if (cnt == 2'd1) state <= S_RELOAD;
               end
            end
            S_RELOAD: begin
               tima  <= tma_next;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (state == S_RELOAD) irq_timer <= 1'b1;
         else if (irq_ack)      irq_timer <= 1'b0;
      end
   end
`else
   logic ovf;
   assign ovf = inc && !wr_tima && (tima == 8'hFF);

   always_ff @(posedge clk) begin
      if (!rst) begin
         tima      <= 8'd0;
         irq_timer <= 1'b0;
      end else begin
         if (wr_tima)  tima <= wdata;
         else if (inc) tima <= (tima == 8'hFF) ? tma_next : tima + 8'd1;
         if (ovf)          irq_timer <= 1'b1;
         else if (irq_ack) irq_timer <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-mapped timer responder on the CPU data bus: answers CPU reads and writes to DIV/TIMA/TMA/TAC (FF04–FF07) over the shared tri-state `databus` with `RE`/`WE` strobes. It owns the free-running 16-bit system counter and the programmable TIMA counter, and raises a timer interrupt request held until acknowledged. It sits beside `sram` on the same bus and decodes only its own four addresses.

## Interface
Parameters:
- `BASE_ADDR`, 16'hFF04: address of DIV; TIMA/TMA/TAC at +1/+2/+3.

Ports:
- `clk` input 1: system clock, all state on posedge.
- `rst` input 1: synchronous, active-low reset (sampled on posedge `clk`).
- `address` input 16: CPU memory address register.
- `databus` inout 8: shared data bus; driven only on a decoded read, else 8'bz.
- `RE` input 1: read strobe.
- `WE` input 1: write strobe; data taken from `databus`.
- `irq_timer` output 1: timer interrupt request, level, sticky.
- `irq_ack` input 1: clears `irq_timer`.

## Operation
- Hit = `address` in BASE_ADDR..BASE_ADDR+3. Non-hit accesses ignored, bus left Z.
- Internal: `sys_cnt[15:0]` +1 every clock; DIV = `sys_cnt[15:8]`. TIMA, TMA 8-bit; TAC 3-bit.
- Reads (combinational while `RE` && hit): DIV → `sys_cnt[15:8]`; TIMA; TMA; TAC → {5'b11111, TAC}.
- Writes (posedge, `WE` && hit): DIV ← any value clears `sys_cnt` to 0; TIMA, TMA ← data; TAC ← data[2:0].
- Tick source: `sel` = `sys_cnt` bit 9/3/5/7 for TAC[1:0] = 00/01/10/11; `tick_in` = `sel` & TAC[2]. TIMA increments on falling edge of `tick_in` (registered previous value vs current). Because DIV write or TAC write can drop `tick_in`, those writes can cause one increment — required, matches hardware.
- Overflow: TIMA = FF and increment → reload TMA, set `irq_timer` (see Configuration for delay).
- Priorities same cycle: CPU write to TIMA beats increment/reload; reload uses TMA value after any same-cycle TMA write; `irq_timer` set beats `irq_ack`.
- `RE` && `WE` together: write performed, read data still driven.

## Timing
- Reset (rst=0 at posedge): `sys_cnt`=0, TIMA=0, TMA=0, TAC=0, `irq_timer`=0, edge-detect reg=0, delay state=IDLE; `databus` Z. Reset mid-delay aborts reload and irq.
- Read data valid same cycle `RE` asserted; CPU samples on next posedge.
- Write visible on register output the cycle after the `WE` edge.
- `sys_cnt` wraps FFFF→0000 silently; TIMA increment period = 1024/16/64/256 clocks.
- `irq_timer` rises the clock after the overflow edge (no-delay build) and stays high until a cycle with `irq_ack`=1 and no new overflow.
- Overflow state machine (delay build): IDLE → on overflow TIMA=00, go WAIT(cnt=3) → decrement each clock → at cnt=0 RELOAD: TIMA←TMA, `irq_timer`←1, return IDLE. TIMA write during WAIT cancels reload and irq (→ IDLE, TIMA = written value). TIMA write in RELOAD cycle ignored (TMA wins).

## Configuration
- `TIMER_OVF_DELAY_EN` defined: 4-clock overflow delay state machine as above (TIMA reads 00 for 4 clocks).
- Undefined: reload and irq set on the same edge as overflow; TIMA never reads 00 from overflow; WAIT/RELOAD states absent.

## Test plan
- Reset then RE at FF04 after 512 clocks → databus=8'h02; FF07 read → 8'hF8; address FF08 read → databus Z.
- TAC=3'b101, TIMA=00 → TIMA=01 after 16 clocks, 04 after 64.
- TMA=8'hAB, TIMA=8'hFF, TAC=3'b101 → after overflow TIMA=AB, `irq_timer`=1 (delay build: TIMA=00 for 4 clocks first); `irq_ack` pulse → 0.
- Delay build: overflow then write TIMA=8'h55 during WAIT → TIMA=55, `irq_timer` stays 0.
- TAC=3'b100, `sys_cnt` bit9=1, write DIV → `sys_cnt`=0 and TIMA increments by exactly 1.
- Overflow and `irq_ack` same cycle → `irq_timer`=1; rst=0 mid-WAIT → all regs 0, no irq.
